// File: rtl/uart_tx.sv
// UART transmitter: 8N1 serial framing of bytes drawn from a small transmit FIFO.
// The line output is registered, so io_tx has no combinational path from any input.
module uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          io_tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW  = PtrW + 1;
    localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);
    localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0]  CntFull  = CntW'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e          state_q, state_d;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [BaudW-1:0] baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;
    logic            push, pop, bit_done;

    assign tx_ready   = count_q < CntFull;
    assign push       = tx_valid && tx_ready;
    assign bit_done   = baud_q == BaudLast;
    assign io_tx      = tx_q;
    assign busy       = (state_q != StIdle) || (count_q != '0);
    assign fifo_count = count_q;

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        if (state_q != StIdle) begin
            baud_d = bit_done ? '0 : baud_q + 1'b1;
        end
        unique case (state_q)
            StIdle: begin
                if (count_q != '0) begin
                    state_d = StStart;
                    pop     = 1'b1;
                    tx_d    = 1'b0;
                    baud_d  = '0;
                end
            end
            StStart: begin
                if (bit_done) begin
                    state_d = StData;
                    tx_d    = shift_q[0];
                    shift_d = {1'b0, shift_q[7:1]};
                end
            end
            StData: begin
                if (bit_done) begin
                    bit_d = bit_q + 1'b1;
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                        tx_d    = 1'b1;
                    end else begin
                        tx_d    = shift_q[0];
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end
            end
            StStop: begin
                if (bit_done) begin
                    // Chain straight into the next start bit to avoid an idle gap.
                    if (count_q != '0) begin
                        state_d = StStart;
                        pop     = 1'b1;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = StIdle;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        if (pop) begin
            shift_d = mem_q[rd_ptr_q];
        end
    end

    assign wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    assign rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    assign count_d  = count_q + CntW'(push) - CntW'(pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem_q[wr_ptr_q] <= tx_data;
        end
    end

endmodule
